// File: rtl/traffic_phase_scheduler.sv
// Demand-driven green/yellow/all-red scheduler for two roads plus an
// optional pedestrian walk phase (enabled by defining PED_CROSSING_EN).
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   on                 enable switch, 0 forces OFF
//   req_a, req_b       vehicle demand per road
//   ped_req            pedestrian button (latched internally)
//   light_a, light_b   lamps: 100 red, 010 yellow, 001 green, 000 dark
//   walk               pedestrian walk lamp
//   ped_pending        latched, unserved pedestrian request
//   phase              current state code
module traffic_phase_scheduler #(
    parameter logic [31:0] MIN_GREEN = 32'd500_000_000,
    parameter logic [31:0] MAX_GREEN = 32'd2_000_000_000,
    parameter logic [31:0] YELLOW    = 32'd200_000_000,
    parameter logic [31:0] ALL_RED   = 32'd100_000_000,
    parameter logic [31:0] WALK      = 32'd700_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       on,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       ped_req,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_A_GREEN  = 3'd1,
        S_A_YELLOW = 3'd2,
        S_AR_AB    = 3'd3,
        S_B_GREEN  = 3'd4,
        S_B_YELLOW = 3'd5,
        S_AR_BA    = 3'd6,
        S_PED_WALK = 3'd7
    } state_t;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [2:0]  light_a_q, light_a_d;
    logic [2:0]  light_b_q, light_b_d;
    logic        walk_q, walk_d;
    logic        comp_a, comp_b;
    logic        exit_a, exit_b;
    logic        is_green;

`ifdef PED_CROSSING_EN
    logic ped_pending_q, ped_pending_d;
    // Road to resume after the walk phase: 1 = B, 0 = A.
    logic next_b_q, next_b_d;
`else
    logic ped_pending_q;
    logic unused_ped_req;
    assign ped_pending_q  = 1'b0;
    assign unused_ped_req = ped_req;
`endif

    // Competing demand for each road's green.
    assign comp_a = req_b | ped_pending_q;
    assign comp_b = req_a | ped_pending_q;

    assign exit_a = (count_q >= MIN_GREEN - 1) && comp_a &&
                    (!req_a || count_q >= MAX_GREEN - 1);
    assign exit_b = (count_q >= MIN_GREEN - 1) && comp_b &&
                    (!req_b || count_q >= MAX_GREEN - 1);

    always_comb begin
        state_d = state_q;
`ifdef PED_CROSSING_EN
        next_b_d = next_b_q;
`endif
        unique case (state_q)
            S_OFF:      state_d = S_A_GREEN;
            S_A_GREEN:  if (exit_a) state_d = S_A_YELLOW;
            S_A_YELLOW: if (count_q >= YELLOW - 1) state_d = S_AR_AB;
            S_AR_AB: begin
                if (count_q >= ALL_RED - 1) begin
                    state_d = S_B_GREEN;
`ifdef PED_CROSSING_EN
                    if (ped_pending_q) begin
                        state_d  = S_PED_WALK;
                        next_b_d = 1'b1;
                    end
`endif
                end
            end
            S_B_GREEN:  if (exit_b) state_d = S_B_YELLOW;
            S_B_YELLOW: if (count_q >= YELLOW - 1) state_d = S_AR_BA;
            S_AR_BA: begin
                if (count_q >= ALL_RED - 1) begin
                    state_d = S_A_GREEN;
`ifdef PED_CROSSING_EN
                    if (ped_pending_q) begin
                        state_d  = S_PED_WALK;
                        next_b_d = 1'b0;
                    end
`endif
                end
            end
`ifdef PED_CROSSING_EN
            S_PED_WALK: begin
                if (count_q >= WALK - 1)
                    state_d = next_b_q ? S_B_GREEN : S_A_GREEN;
            end
`endif
            default:    state_d = S_OFF;
        endcase
        if (!on) state_d = S_OFF;

        // Green count saturates so an idle green can rest forever.
        is_green = (state_q == S_A_GREEN) || (state_q == S_B_GREEN);
        if (!on || state_d != state_q)
            count_d = '0;
        else if (is_green && count_q >= MAX_GREEN - 1)
            count_d = count_q;
        else
            count_d = count_q + 32'd1;

`ifdef PED_CROSSING_EN
        ped_pending_d = ped_pending_q;
        if (ped_req && state_q != S_PED_WALK) ped_pending_d = 1'b1;
        // Clear wins over a same-edge set.
        if (state_d == S_PED_WALK && state_q != S_PED_WALK)
            ped_pending_d = 1'b0;
        if (!on) ped_pending_d = 1'b0;
`endif

        // Lamps follow the next state so they change with it.
        light_a_d = L_RED;
        light_b_d = L_RED;
        walk_d    = 1'b0;
        unique case (state_d)
            S_OFF: begin
                light_a_d = L_OFF;
                light_b_d = L_OFF;
            end
            S_A_GREEN:  light_a_d = L_GRN;
            S_A_YELLOW: light_a_d = L_YEL;
            S_B_GREEN:  light_b_d = L_GRN;
            S_B_YELLOW: light_b_d = L_YEL;
            S_PED_WALK: walk_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            count_q   <= '0;
            light_a_q <= L_OFF;
            light_b_q <= L_OFF;
            walk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            light_a_q <= light_a_d;
            light_b_q <= light_b_d;
            walk_q    <= walk_d;
        end
    end

`ifdef PED_CROSSING_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending_q <= 1'b0;
            next_b_q      <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            next_b_q      <= next_b_d;
        end
    end
`endif

    assign light_a     = light_a_q;
    assign light_b     = light_b_q;
    assign walk        = walk_q;
    assign ped_pending = ped_pending_q;
    assign phase       = state_q;

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler for a two-road intersection with an optional pedestrian crossing. It sequences green, yellow and all-red clearance between road A and road B, using vehicle-sensor requests and a pedestrian button. It enforces minimum green, maximum green, yellow, all-red and walk durations counted in `clk` cycles. It drives the per-road lamp outputs directly and sits between the board switches/sensors and the lamp pins, replacing fixed-time cycling.

## Interface
- `MIN_GREEN`, 500_000_000, minimum green duration in cycles (5 s at 100 MHz)
- `MAX_GREEN`, 2_000_000_000, maximum green duration under competing demand in cycles; must be ≥ `MIN_GREEN`
- `YELLOW`, 200_000_000, yellow duration in cycles
- `ALL_RED`, 100_000_000, all-red clearance duration in cycles
- `WALK`, 700_000_000, pedestrian walk duration in cycles; all durations ≥ 1
- `clk`  in  1  system clock
- `rst_n`  in  1  one clock; reset is asynchronous and active-low
- `on`  in  1  system enable switch; 0 forces OFF
- `req_a` / `req_b`  in  1 each  vehicle demand level for road A / road B
- `ped_req`  in  1  pedestrian button; a pulse of any length ≥1 cycle is sufficient
- `light_a` / `light_b`  out  3 each  lamps: 100 red, 010 yellow, 001 green, 000 dark
- `walk`  out  1  pedestrian walk lamp
- `ped_pending`  out  1  latched pedestrian request not yet served
- `phase`  out  3  current state code

## Operation
- States and `phase` codes: OFF=0, A_GREEN=1, A_YELLOW=2, AR_AB=3, B_GREEN=4, B_YELLOW=5, AR_BA=6, PED_WALK=7.
- One 32-bit `count` is cleared on every state entry and increments each cycle in a state.
- Lamps by state:
  - OFF: 000/000.
  - A_GREEN: A=001, B=100.
  - A_YELLOW: A=010, B=100.
  - B_GREEN: A=100, B=001.
  - B_YELLOW: A=100, B=010.
  - AR_AB, AR_BA and PED_WALK: A=100, B=100.
  - `walk`=1 only in PED_WALK.
- OFF → A_GREEN when `on`=1.
- Green state for road X, where the competing demand is the other road's `req` OR `ped_pending`:
  - Exit to X_YELLOW when `count` ≥ MIN_GREEN−1, competing demand is present, and either `req_X`=0 (gap-out) or `count` ≥ MAX_GREEN−1 (max-out).
  - With no competing demand, the green rests indefinitely. `count` saturates at MAX_GREEN−1.
- X_YELLOW → AR_XY after YELLOW cycles.
- AR_AB after ALL_RED cycles:
  - → PED_WALK if `ped_pending`=1, with the next road set to B.
  - Otherwise → B_GREEN.
- AR_BA after ALL_RED cycles:
  - → PED_WALK if `ped_pending`=1, with the next road set to A.
  - Otherwise → A_GREEN.
- PED_WALK → green of the stored next road after WALK cycles.
- `ped_pending` is set on any cycle with `ped_req`=1 outside PED_WALK, and cleared on the PED_WALK entry edge. `ped_req` during PED_WALK is ignored. A set and a clear on the same edge resolve to clear.
- `on`=0 in any state: the next edge enters OFF, clears `count`, clears `ped_pending`, and sets lamps to 000. No yellow is inserted.
- Any unused or illegal state code goes to OFF on the next edge.

## Timing
- `rst_n` low asynchronously forces: state OFF, `count`=0, `ped_pending`=0, `light_a`=`light_b`=000, `walk`=0, `phase`=0.
- All outputs are registered and update on the same edge as the state. There are no combinational paths from inputs to outputs.
- Fixed states (yellow, all-red, walk) last exactly N cycles. Green lasts at least MIN_GREEN cycles. Under continuous competing demand, green lasts at most MAX_GREEN cycles.
- `req_a`/`req_b`/`ped_req` are sampled synchronously. They must be synchronized upstream.
- `ped_req` asserted at edge k shows `ped_pending`=1 after edge k.

## Configuration
- `PED_CROSSING_EN` defined:
  - Pedestrian path is present as described.
- `PED_CROSSING_EN` undefined:
  - `ped_req` is ignored.
  - `ped_pending` and `walk` are tied to 0.
  - PED_WALK is unreachable (code 7 is treated as illegal → OFF).
  - Competing demand is the other road's `req` only.

## Test plan
Bench parameters: MIN_GREEN=4, MAX_GREEN=10, YELLOW=2, ALL_RED=1, WALK=3; `PED_CROSSING_EN` defined unless noted.
- Reset/enable:
  - Stimulus: `rst_n`=0 mid-A_GREEN with no clock edge.
  - Response: outputs immediately 000/000, `phase`=0.
  - Stimulus: release reset, then `on`=1.
  - Response: one edge later `phase`=1, A=001, B=100.
- Rest in green:
  - Stimulus: `req_b`=0, `ped_req`=0 for 50 cycles.
  - Response: `phase` stays 1 throughout.
- Gap-out:
  - Stimulus: `req_b`=1 and `req_a`=0 from A_GREEN entry.
  - Response: A_GREEN 4 cycles, A_YELLOW 2, AR_AB 1, then `phase`=4 with B=001.
- Max-out:
  - Stimulus: `req_a`=`req_b`=1 held.
  - Response: A_GREEN exactly 10 cycles, then B_GREEN exactly 10 cycles, alternating.
- Pedestrian:
  - Stimulus: 1-cycle `ped_req` in B_GREEN with `req_a`=0.
  - Response: `ped_pending`=1 next cycle. Then B_YELLOW 2, AR_BA 1, PED_WALK 3 with `walk`=1 and `ped_pending`=0, then A_GREEN.
  - Stimulus: repeat with the macro undefined.
  - Response: B_GREEN rests, `walk` never asserts.
- Disable mid-cycle:
  - Stimulus: `on`=0 during A_YELLOW with `ped_pending`=1.
  - Response: next edge `phase`=0, lamps 000, `ped_pending`=0.
  - Stimulus: `on`=1 again.
  - Response: A_GREEN with `count` restarting from 0.
